// File: rtl/mod_uart_fifo.sv
// mod_uart_fifo: memory-mapped 8N1 UART with optional parity, TX/RX FIFOs,
// programmable baud divisor and sticky error flags.
//
// All state updates on the falling clock edge, the same edge as the data bus.
//
// Ports:
//   clk    system clock (state updates on negedge)
//   rst    synchronous active-high reset
//   ie     instruction enable (ignored)
//   de     data enable
//   iaddr  instruction address (ignored)
//   daddr  data address, offset within the block
//   drw    bus direction, drw[0]=1 is a write
//   din    write data
//   iout   constant 0
//   dout   read data, combinational from daddr
//   txd    serial out, idle high
//   rxd    serial in, asynchronous
//
// Register map:
//   0x00 CMD     W: [0] pop RX, [1] flush RX, [2] flush TX, [3] clear flags
//   0x04 STATUS  R: [0] tx_not_full [1] rx_rdy [2] tx_idle [3] parity_err
//                   [4] frame_err [5] rx_overrun [6] tx_overflow
//                   [15:8] rx_count [23:16] tx_count
//   0x08 RXDATA  R: RX head, 0 when empty
//   0x0c TXDATA  W: push din[7:0] into TX
//   0x10 CONFIG  RW: [15:0] divisor, [17:16] parity (01 even, 10 odd)
module mod_uart_fifo #(
  parameter int unsigned CLK_RATE   = 25000000,
  parameter int unsigned BAUD_RATE  = 57600,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ie,
  input  logic        de,
  input  logic [31:0] iaddr,
  input  logic [31:0] daddr,
  input  logic [1:0]  drw,
  input  logic [31:0] din,
  output logic [31:0] iout,
  output logic [31:0] dout,
  output logic        txd,
  input  logic        rxd
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(FIFO_DEPTH);
  localparam logic [15:0] DivRst = 16'(CLK_RATE / (16 * BAUD_RATE) - 1);

  localparam logic [31:0] AddrCmd    = 32'h00;
  localparam logic [31:0] AddrStatus = 32'h04;
  localparam logic [31:0] AddrRxData = 32'h08;
  localparam logic [31:0] AddrTxData = 32'h0c;
  localparam logic [31:0] AddrConfig = 32'h10;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic wr;
  logic cmd_wr, cfg_wr, txdata_wr;
  logic cmd_pop, cmd_rx_flush, cmd_tx_flush, cmd_clr;

  assign wr           = de & drw[0];
  assign cmd_wr       = wr & (daddr == AddrCmd);
  assign cfg_wr       = wr & (daddr == AddrConfig);
  assign txdata_wr    = wr & (daddr == AddrTxData);
  assign cmd_pop      = cmd_wr & din[0];
  assign cmd_rx_flush = cmd_wr & din[1];
  assign cmd_tx_flush = cmd_wr & din[2];
  assign cmd_clr      = cmd_wr & din[3];

  logic unused_ok;
  assign unused_ok = ^{ie, iaddr, drw[1], din[31:18]};

  assign iout = 32'h0;

  // ---------------------------------------------------------------------------
  // Configuration and 16x tick generator
  // ---------------------------------------------------------------------------
  logic [15:0] div_q, tick_cnt_q;
  logic [1:0]  par_mode_q;
  logic        tick, par_en, par_odd;

  assign tick    = (tick_cnt_q == div_q);
  assign par_en  = (par_mode_q == 2'b01) | (par_mode_q == 2'b10);
  assign par_odd = (par_mode_q == 2'b10);

  // A CONFIG write restarts the tick phase so the new divisor applies at once.
  always_ff @(negedge clk) begin
    if (rst) begin
      div_q      <= DivRst;
      par_mode_q <= 2'b00;
      tick_cnt_q <= 16'h0;
    end else if (cfg_wr) begin
      div_q      <= din[15:0];
      par_mode_q <= din[17:16];
      tick_cnt_q <= 16'h0;
    end else if (tick) begin
      tick_cnt_q <= 16'h0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] tx_wptr_q, tx_rptr_q;
  logic [CW-1:0] tx_cnt_q;
  logic          tx_full, tx_empty, tx_push, tx_pop, tx_ovf_set, tx_load;

  assign tx_full    = (tx_cnt_q == FullCnt);
  assign tx_empty   = (tx_cnt_q == '0);
  assign tx_push    = txdata_wr & ~tx_full;
  assign tx_ovf_set = txdata_wr & tx_full;
  assign tx_pop     = tx_load;

  always_ff @(negedge clk) begin
    if (rst || cmd_tx_flush) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
      tx_cnt_q <= tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    end
  end

  always_ff @(negedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= din[7:0];
  end

  // ---------------------------------------------------------------------------
  // TX shifter
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;

  tx_state_e  tx_state_q, tx_state_d;
  logic [3:0] tx_sub_q, tx_sub_d;
  logic [2:0] tx_idx_q, tx_idx_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_bit_end, tx_idle;

  assign tx_bit_end = tick & (tx_sub_q == 4'd15);
  // Loading straight out of STOP keeps back-to-back bytes gapless.
  assign tx_load    = ~tx_empty & ((tx_state_q == TxIdle) |
                                   ((tx_state_q == TxStop) & tx_bit_end));
  assign tx_idle    = tx_empty & (tx_state_q == TxIdle);

  always_ff @(negedge clk) begin
    if (rst) begin
      tx_state_q <= TxIdle;
      tx_sub_q   <= 4'h0;
      tx_idx_q   <= 3'h0;
      tx_byte_q  <= 8'h0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_sub_q   <= tx_sub_d;
      tx_idx_q   <= tx_idx_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      TxIdle:   if (tx_load) tx_state_d = TxStart;
      TxStart:  if (tx_bit_end) tx_state_d = TxData;
      TxData:   if (tx_bit_end && tx_idx_q == 3'd7) tx_state_d = par_en ? TxParity : TxStop;
      TxParity: if (tx_bit_end) tx_state_d = TxStop;
      TxStop:   if (tx_bit_end) tx_state_d = tx_load ? TxStart : TxIdle;
      default:  tx_state_d = TxIdle;
    endcase
  end

  always_comb begin
    tx_sub_d  = tx_sub_q;
    tx_idx_d  = tx_idx_q;
    tx_byte_d = tx_byte_q;
    if (tx_load) begin
      tx_sub_d  = 4'h0;
      tx_idx_d  = 3'h0;
      tx_byte_d = tx_mem_q[tx_rptr_q];
    end else if (tx_state_q != TxIdle && tick) begin
      tx_sub_d = tx_sub_q + 4'd1;
      if (tx_bit_end && tx_state_q == TxData) tx_idx_d = tx_idx_q + 3'd1;
    end
  end

  always_comb begin
    txd = 1'b1;
    unique case (tx_state_q)
      TxIdle:   txd = 1'b1;
      TxStart:  txd = 1'b0;
      TxData:   txd = tx_byte_q[tx_idx_q];
      TxParity: txd = (^tx_byte_q) ^ par_odd;
      TxStop:   txd = 1'b1;
      default:  txd = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // RX synchronizer and shifter
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    RxIdle, RxStart, RxData, RxParity, RxStop, RxWaitHigh
  } rx_state_e;

  logic       rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e  rx_state_q, rx_state_d;
  logic [3:0] rx_sub_q, rx_sub_d;
  logic [2:0] rx_idx_q, rx_idx_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_par_q, rx_par_d;
  logic       rx_fall, rx_sample;
  logic       rx_frame_ok, rx_frame_bad, rx_par_bad;

  always_ff @(negedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rxd;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign rx_fall   = rx_prev_q & ~rx_s2_q;
  // Start is confirmed half a bit in; every later sample is a full bit apart.
  assign rx_sample = tick & ((rx_state_q == RxStart) ? (rx_sub_q == 4'd7)
                                                     : (rx_sub_q == 4'd15));

  always_ff @(negedge clk) begin
    if (rst) begin
      rx_state_q <= RxIdle;
      rx_sub_q   <= 4'h0;
      rx_idx_q   <= 3'h0;
      rx_byte_q  <= 8'h0;
      rx_par_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_sub_q   <= rx_sub_d;
      rx_idx_q   <= rx_idx_d;
      rx_byte_q  <= rx_byte_d;
      rx_par_q   <= rx_par_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      RxIdle:     if (rx_fall) rx_state_d = RxStart;
      RxStart:    if (rx_sample) rx_state_d = rx_s2_q ? RxIdle : RxData;
      RxData:     if (rx_sample && rx_idx_q == 3'd7) rx_state_d = par_en ? RxParity : RxStop;
      RxParity:   if (rx_sample) rx_state_d = RxStop;
      RxStop:     if (rx_sample) rx_state_d = rx_s2_q ? RxIdle : RxWaitHigh;
      RxWaitHigh: if (rx_s2_q) rx_state_d = RxIdle;
      default:    rx_state_d = RxIdle;
    endcase
  end

  always_comb begin
    rx_sub_d  = rx_sub_q;
    rx_idx_d  = rx_idx_q;
    rx_byte_d = rx_byte_q;
    rx_par_d  = rx_par_q;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_fall) begin
          rx_sub_d = 4'h0;
          rx_idx_d = 3'h0;
        end
      end
      RxStart: begin
        if (tick) rx_sub_d = rx_sample ? 4'h0 : rx_sub_q + 4'd1;
      end
      RxData: begin
        if (tick) rx_sub_d = rx_sub_q + 4'd1;
        if (rx_sample) begin
          rx_byte_d = {rx_s2_q, rx_byte_q[7:1]};
          rx_idx_d  = rx_idx_q + 3'd1;
        end
      end
      RxParity: begin
        if (tick) rx_sub_d = rx_sub_q + 4'd1;
        if (rx_sample) rx_par_d = rx_s2_q;
      end
      RxStop: begin
        if (tick) rx_sub_d = rx_sub_q + 4'd1;
      end
      default: ;
    endcase
  end

  assign rx_frame_ok  = (rx_state_q == RxStop) & rx_sample & rx_s2_q;
  assign rx_frame_bad = (rx_state_q == RxStop) & rx_sample & ~rx_s2_q;
  assign rx_par_bad   = rx_frame_ok & par_en & (rx_par_q != ((^rx_byte_q) ^ par_odd));

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] rx_wptr_q, rx_rptr_q;
  logic [CW-1:0] rx_cnt_q;
  logic          rx_full, rx_empty, rx_push, rx_pop, rx_ovr_set;
  logic [7:0]    rx_head;

  assign rx_full    = (rx_cnt_q == FullCnt);
  assign rx_empty   = (rx_cnt_q == '0);
  assign rx_push    = rx_frame_ok & ~rx_full;
  assign rx_ovr_set = rx_frame_ok & rx_full;
  assign rx_pop     = cmd_pop & ~rx_empty;
  assign rx_head    = rx_empty ? 8'h0 : rx_mem_q[rx_rptr_q];

  always_ff @(negedge clk) begin
    if (rst || cmd_rx_flush) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
      rx_cnt_q <= rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    end
  end

  always_ff @(negedge clk) begin
    if (rx_push) rx_mem_q[rx_wptr_q] <= rx_byte_q;
  end

  // ---------------------------------------------------------------------------
  // Sticky flags: a set in the same cycle as a clear wins
  // ---------------------------------------------------------------------------
  logic par_err_q, frame_err_q, rx_ovr_q, tx_ovf_q;

  always_ff @(negedge clk) begin
    if (rst) begin
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_ovr_q    <= 1'b0;
      tx_ovf_q    <= 1'b0;
    end else begin
      par_err_q   <= rx_par_bad   | (par_err_q   & ~cmd_clr);
      frame_err_q <= rx_frame_bad | (frame_err_q & ~cmd_clr);
      rx_ovr_q    <= rx_ovr_set   | (rx_ovr_q    & ~cmd_clr);
      tx_ovf_q    <= tx_ovf_set   | (tx_ovf_q    & ~cmd_clr);
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [31:0] status;

  always_comb begin
    status        = 32'h0;
    status[0]     = ~tx_full;
    status[1]     = ~rx_empty;
    status[2]     = tx_idle;
    status[3]     = par_err_q;
    status[4]     = frame_err_q;
    status[5]     = rx_ovr_q;
    status[6]     = tx_ovf_q;
    status[15:8]  = 8'(rx_cnt_q);
    status[23:16] = 8'(tx_cnt_q);
  end

  always_comb begin
    dout = 32'h0;
    case (daddr)
      AddrStatus: dout = status;
      AddrRxData: dout = {24'h0, rx_head};
      AddrConfig: dout = {14'h0, par_mode_q, div_q};
      default:    dout = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_mod_uart_fifo.sv
// Directed-plus-random bench for mod_uart_fifo. Expected register values come
// from a queue-based model of the UART's documented behaviour.
module tb_mod_uart_fifo;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, ie, de, txd, rxd;
  logic [31:0] iaddr, daddr, din, iout, dout;
  logic [1:0]  drw;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  bit         par_err_m, frame_err_m, rx_ovr_m, tx_ovf_m, tx_busy_m;
  int         div_m;
  logic [1:0] par_m;

  always #5 clk = ~clk;

  mod_uart_fifo #(
    .CLK_RATE  (25000000),
    .BAUD_RATE (57600),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ie   (ie),
    .de   (de),
    .iaddr(iaddr),
    .daddr(daddr),
    .drw  (drw),
    .din  (din),
    .iout (iout),
    .dout (dout),
    .txd  (txd),
    .rxd  (rxd)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s        = 32'h0;
    s[0]     = (tx_q.size() < DEPTH);
    s[1]     = (rx_q.size() != 0);
    s[2]     = (tx_q.size() == 0) && !tx_busy_m;
    s[3]     = par_err_m;
    s[4]     = frame_err_m;
    s[5]     = rx_ovr_m;
    s[6]     = tx_ovf_m;
    s[15:8]  = 8'(rx_q.size());
    s[23:16] = 8'(tx_q.size());
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk);
    de = 1'b1; drw = 2'b01; daddr = addr; din = data;
    @(posedge clk);
    de = 1'b0; drw = 2'b00; daddr = 32'h4;
  endtask

  task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data);
    @(posedge clk);
    daddr = addr;
    #1 data = dout;
  endtask

  // Drive one serial frame on rxd, then update the model with its outcome.
  task automatic send_frame(input logic [7:0] b, input bit pen, input bit pbit, input bit stop);
    int bp;
    bp = 16 * (div_m + 1);
    rxd = 1'b0;
    repeat (bp) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (bp) @(posedge clk);
    end
    if (pen) begin
      rxd = pbit;
      repeat (bp) @(posedge clk);
    end
    rxd = stop;
    repeat (bp) @(posedge clk);
    rxd = 1'b1;
    repeat (bp) @(posedge clk);
    if (stop) begin
      if (pen && (pbit != ((^b) ^ (par_m == 2'b10)))) par_err_m = 1'b1;
      if (rx_q.size() < DEPTH) rx_q.push_back(b);
      else rx_ovr_m = 1'b1;
    end else begin
      frame_err_m = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    int          n;

    rst = 1'b1; ie = 1'b0; de = 1'b0; drw = 2'b00;
    iaddr = 32'h0; daddr = 32'h4; din = 32'h0; rxd = 1'b1;
    par_err_m = 0; frame_err_m = 0; rx_ovr_m = 0; tx_ovf_m = 0; tx_busy_m = 0;
    div_m = 26; par_m = 2'b00;
    repeat (3) @(posedge clk);
    rst = 1'b0;

    // Reset state
    bus_rd(32'h04, rd); check("reset_status", rd, exp_status());
    bus_rd(32'h10, rd); check("reset_config", rd, 32'd26);
    bus_rd(32'h08, rd); check("rxdata_empty", rd, 32'h0);
    bus_rd(32'h00, rd); check("cmd_reads_zero", rd, 32'h0);
    check("reset_txd", {31'h0, txd}, 32'h1);
    check("iout_zero", iout, 32'h0);

    // TX serial shape, no parity, 32 clk per bit
    bus_wr(32'h10, 32'h1); div_m = 1;
    bus_wr(32'h0c, 32'h55); tx_busy_m = 1;
    n = 0;
    while (txd !== 1'b0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("tx_start_seen", {31'h0, n < 100}, 32'h1);
    repeat (16) @(posedge clk); #1;
    check("tx_start_bit", {31'h0, txd}, 32'h0);
    check("tx_busy_status", dout, exp_status());
    b = 8'h55;
    for (int i = 0; i < 8; i++) begin
      repeat (32) @(posedge clk); #1;
      check($sformatf("tx_d%0d", i), {31'h0, txd}, {31'h0, b[i]});
    end
    repeat (32) @(posedge clk); #1;
    check("tx_stop_bit", {31'h0, txd}, 32'h1);
    repeat (40) @(posedge clk);
    tx_busy_m = 0;
    bus_rd(32'h04, rd); check("tx_idle_after", rd, exp_status());

    // RX even parity, good then bad parity bit
    bus_wr(32'h10, 32'h0001_0001); par_m = 2'b01;
    send_frame(8'hA5, 1, 1'b0, 1);
    bus_rd(32'h04, rd); check("rx_even_ok_status", rd, exp_status());
    bus_rd(32'h08, rd); check("rx_even_ok_data", rd, {24'h0, rx_q[0]});
    bus_wr(32'h00, 32'h1); void'(rx_q.pop_front());
    send_frame(8'hA5, 1, 1'b1, 1);
    bus_rd(32'h04, rd); check("rx_parity_err_status", rd, exp_status());
    bus_rd(32'h08, rd); check("rx_parity_err_data", rd, {24'h0, rx_q[0]});

    // RX odd parity, random byte
    bus_wr(32'h10, 32'h0002_0001); par_m = 2'b10;
    b = 8'($urandom);
    send_frame(b, 1, ~(^b), 1);
    bus_rd(32'h04, rd); check("rx_odd_status", rd, exp_status());

    // Flush RX and clear flags together
    bus_wr(32'h00, 32'ha);
    rx_q.delete(); par_err_m = 0; frame_err_m = 0; rx_ovr_m = 0; tx_ovf_m = 0;
    bus_rd(32'h04, rd); check("flush_clear_status", rd, exp_status());

    // Overrun: DEPTH+1 random frames, no pops
    bus_wr(32'h10, 32'h0001_0001); par_m = 2'b01;
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      send_frame(b, 1, ^b, 1);
    end
    bus_rd(32'h04, rd); check("rx_overrun_status", rd, exp_status());
    for (int i = 0; i < DEPTH; i++) begin
      bus_rd(32'h08, rd); check($sformatf("rx_drain_%0d", i), rd, {24'h0, rx_q[0]});
      bus_wr(32'h00, 32'h1); void'(rx_q.pop_front());
    end
    bus_wr(32'h00, 32'h1);  // pop on empty is ignored
    bus_rd(32'h04, rd); check("rx_drained_status", rd, exp_status());
    bus_wr(32'h00, 32'h8);
    par_err_m = 0; frame_err_m = 0; rx_ovr_m = 0; tx_ovf_m = 0;
    bus_rd(32'h04, rd); check("flags_cleared", rd, exp_status());

    // Short glitch is rejected
    @(posedge clk); rxd = 1'b0;
    repeat (4) @(posedge clk); rxd = 1'b1;
    repeat (64) @(posedge clk);
    bus_rd(32'h04, rd); check("glitch_status", rd, exp_status());

    // Framing error: byte discarded
    b = 8'($urandom);
    send_frame(b, 1, ^b, 0);
    bus_rd(32'h04, rd); check("frame_err_status", rd, exp_status());
    bus_wr(32'h00, 32'h8); frame_err_m = 0;

    // TX overflow: shifter busy, then 17 back-to-back pushes
    bus_wr(32'h0c, 32'($urandom_range(0, 255))); tx_busy_m = 1;
    repeat (3) @(posedge clk);
    for (int i = 0; i < DEPTH + 1; i++) begin
      @(posedge clk);
      de = 1'b1; drw = 2'b01; daddr = 32'h0c; din = 32'($urandom_range(0, 255));
      if (tx_q.size() < DEPTH) tx_q.push_back(din[7:0]);
      else tx_ovf_m = 1'b1;
    end
    @(posedge clk);
    de = 1'b0; drw = 2'b00; daddr = 32'h4;
    #1 check("tx_overflow_status", dout, exp_status());

    // Reset while a frame is on the wire
    n = 0;
    while (txd !== 1'b0 && n < 500) begin
      @(posedge clk); #1; n++;
    end
    check("tx_low_before_rst", {31'h0, n < 500}, 32'h1);
    @(posedge clk); rst = 1'b1;
    @(posedge clk); rst = 1'b0;
    #1;
    tx_q.delete(); rx_q.delete(); tx_busy_m = 0;
    par_err_m = 0; frame_err_m = 0; rx_ovr_m = 0; tx_ovf_m = 0;
    check("rst_txd_high", {31'h0, txd}, 32'h1);
    check("rst_status", dout, exp_status());
    bus_rd(32'h10, rd); check("rst_config", rd, 32'd26);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
